fadd_result_wb: RTL and testbench
=================================

Name: fadd_result_wb

Overview:
Writeback/result stage directly downstream of the combinational FP add/sub unit. Each cycle it can capture the unit's raw result together with the original operands and destination register. It applies RISC-V special-case fix-ups (NaN, infinity, overflow), generates fflags, and buffers results in a small FIFO. Results drain toward the FP register file write port through a valid/ready handshake.

Parameters:
XLEN, 32, operand/result width (only 32 supported).
REG_ADDR, 5, destination register index width.
DEPTH, 2, FIFO entries; must be a power of 2, minimum 2.

Ports:
CLK  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
flush  input  1  synchronous clear of all buffered results.
in_valid  input  1  upstream result valid.
in_ready  output  1  stage can accept; equals !full.
in_frs1  input  XLEN  original operand 1.
in_frs2  input  XLEN  original operand 2.
in_funct  input  1  0 = add, 1 = sub.
in_frd  input  XLEN  raw add/sub result.
in_rd  input  REG_ADDR  destination register.
out_valid  output  1  head entry valid.
out_ready  input  1  regfile accepts head.
out_data  output  XLEN  fixed-up result.
out_rd  output  REG_ADDR  destination register of head.
out_fflags  output  5  flags of head entry, {NV,DZ,OF,UF,NX}.
fflags_acc  output  5  sticky OR of fflags of all popped entries.
fflags_clr  input  1  synchronous clear of fflags_acc.

Behaviour:
- Reset (async, rst_n=0): rd/wr pointers and count = 0; out_valid=0; in_ready=1; out_data, out_rd, out_fflags, fflags_acc = 0; storage contents don't-care.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated on the same edge.
- Latency: an entry pushed at edge N appears on the out_* ports after edge N (one cycle). There is no combinational in-to-out path unless the optional feature is enabled.
- in_ready = (count != DEPTH). It is registered-state based only; there is no combinational dependence on out_ready. When full, a same-cycle pop does not enable a push.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Fix-up is combinational on the input side and evaluated before the write. Effective subtraction = sign1 ^ sign2 ^ in_funct. Field decode: exp = bits[30:23], man = bits[22:0].
  * NaN = exp 0xFF and man != 0. sNaN = NaN with man[22]=0.
  * Either operand NaN: data = 0x7FC00000; NV=1 if either operand is sNaN.
  * Else both operands inf with effective subtraction: data = 0x7FC00000, NV=1.
  * Else either operand inf: data = that inf. For operand 2, the sign is flipped when in_funct=1.
  * Else in_frd exp == 0xFF (overflow): data = {in_frd[31], 0x7F800000[30:0]}, OF=1, NX=1.
  * Else data = in_frd with all flags 0.
  * DZ and UF are always 0.
- Priority: NaN > inf-inf > inf > overflow > pass.
- out_data, out_rd and out_fflags reflect the head entry. They hold stable while out_valid=1 and out_ready=0.
- fflags_acc |= out_fflags on every pop. fflags_clr clears it; if clear and pop occur in the same cycle, the accumulator takes the popped flags only.
- flush: pointers and count go to 0 on the next edge. A same-cycle push is dropped. A same-cycle pop is not accumulated. fflags_acc is unaffected by flush.
- Reset asserted mid-operation discards all entries immediately; out_valid falls asynchronously.

Optional Feature:
FADD_WB_BYPASS_EN
- Defined: when count==0, in_valid=1 and out_ready=1, the fixed-up input is presented combinationally on the out_* ports with out_valid=1 and consumed the same cycle (zero latency, no write). in_ready stays based on count only.
- Not defined: fixed one-cycle latency; no combinational in-to-out path.

Test Plan:
- Basic add: frs1=0x3F800000, frs2=0x40000000, funct=0, frd=0x40400000, rd=5, out_ready=1 → next cycle out_valid=1, out_data=0x40400000, out_rd=5, out_fflags=0.
- Invalid: frs1=0x7F800000, frs2=0xFF800000, funct=0 → out_data=0x7FC00000, out_fflags=5'b10000; then pop with fflags_clr=0 → fflags_acc=5'b10000.
- NaN handling: frs1=0x7F800001 (sNaN), frs2=0x3F800000 → 0x7FC00000, NV=1. frs1=0x7FC00001 (qNaN) → 0x7FC00000, flags 0.
- Overflow: frs1=frs2=0x7F7FFFFF, frd=0x7F800000 → out_data=0x7F800000, out_fflags=5'b00101.
- Backpressure (DEPTH=2): out_ready=0, push rd=1,2,3 on consecutive cycles → in_ready=0 after 2 pushes, rd=3 held upstream. Then out_ready=1 → pops in order 1, 2, 3, and in_ready returns to 1 the cycle after the first pop.
- Flush/reset: with 2 entries queued, pulse flush with a simultaneous push → next cycle out_valid=0 and count=0. Repeat with rst_n low mid-drain → out_valid=0 immediately and fflags_acc=0.

Source files
------------

// File: rtl/fadd_result_wb.sv
// fadd_result_wb: writeback/result stage behind the combinational FP add/sub.
//
// It captures the raw add/sub result with its operands and destination. It
// applies the RISC-V special-case fix-ups (NaN, invalid inf-inf, infinity
// propagation, overflow) and generates fflags. Results are buffered in a
// DEPTH-entry FIFO that drains to the FP regfile through a valid/ready handshake.
//
// Ports:
//   CLK, rst_n        clock (rising edge), async active-low reset
//   flush             synchronous clear of all buffered results
//   in_valid/in_ready upstream handshake; in_ready = !full (state only)
//   in_frs1, in_frs2  original operands
//   in_funct          0 = add, 1 = sub
//   in_frd            raw add/sub result
//   in_rd             destination register
//   out_valid/out_ready  regfile handshake for the head entry
//   out_data, out_rd, out_fflags  head entry ({NV,DZ,OF,UF,NX})
//   fflags_acc        sticky OR of the flags of every popped entry
//   fflags_clr        synchronous clear of fflags_acc
//
// Optional feature macro: FADD_WB_BYPASS_EN
//   When it is defined and the FIFO is empty, an input presented while
//   out_ready=1 goes straight to the out_* ports. It is consumed in the same
//   cycle and is never written into the FIFO. When it is undefined, latency is
//   a fixed one cycle.

// Combinational special-case fix-up of one add/sub result.
module fadd_wb_fixup #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] frs1,
    input  logic [XLEN-1:0] frs2,
    input  logic            funct,
    input  logic [XLEN-1:0] frd,
    output logic [XLEN-1:0] data,
    output logic [4:0]      fflags
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    logic nan1, nan2, snan1, snan2, inf1, inf2, eff_sub, ovf;

    always_comb begin
        nan1    = (frs1[30:23] == 8'hFF) && (frs1[22:0] != 23'd0);
        nan2    = (frs2[30:23] == 8'hFF) && (frs2[22:0] != 23'd0);
        snan1   = nan1 && !frs1[22];
        snan2   = nan2 && !frs2[22];
        inf1    = (frs1[30:23] == 8'hFF) && (frs1[22:0] == 23'd0);
        inf2    = (frs2[30:23] == 8'hFF) && (frs2[22:0] == 23'd0);
        // A subtract of operand 2 flips its sign, so the effective operation
        // depends on both signs and the opcode.
        eff_sub = frs1[31] ^ frs2[31] ^ funct;
        ovf     = (frd[30:23] == 8'hFF);

        data   = frd;
        fflags = 5'b00000;
        if (nan1 || nan2) begin
            data      = QNAN;
            fflags[4] = snan1 || snan2;
        end else if (inf1 && inf2 && eff_sub) begin
            data      = QNAN;
            fflags[4] = 1'b1;
        end else if (inf1) begin
            // Both infinite with the same effective sign lands here as well.
            // Operand 1 then already carries the correct sign.
            data = frs1;
        end else if (inf2) begin
            data = {frs2[31] ^ funct, frs2[30:0]};
        end else if (ovf) begin
            data   = {frd[31], PINF[30:0]};
            fflags = 5'b00101;
        end
    end
endmodule

module fadd_result_wb #(
    parameter int XLEN     = 32,
    parameter int REG_ADDR = 5,
    parameter int DEPTH    = 2
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_frs1,
    input  logic [XLEN-1:0]     in_frs2,
    input  logic                in_funct,
    input  logic [XLEN-1:0]     in_frd,
    input  logic [REG_ADDR-1:0] in_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic [REG_ADDR-1:0] out_rd,
    output logic [4:0]          out_fflags,
    output logic [4:0]          fflags_acc,
    input  logic                fflags_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0]     data;
        logic [REG_ADDR-1:0] rd;
        logic [4:0]          fflags;
    } wb_entry_t;

    wb_entry_t           mem [DEPTH];
    wb_entry_t           in_ent;
    wb_entry_t           head;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                fifo_valid;
    logic                bypass;
    logic                push, pop, push_wr, pop_fifo;
    logic [XLEN-1:0]     fix_data;
    logic [4:0]          fix_flags;

    fadd_wb_fixup #(.XLEN(XLEN)) u_fixup (
        .frs1   (in_frs1),
        .frs2   (in_frs2),
        .funct  (in_funct),
        .frd    (in_frd),
        .data   (fix_data),
        .fflags (fix_flags)
    );

    always_comb begin
        in_ent.data   = fix_data;
        in_ent.rd     = in_rd;
        in_ent.fflags = fix_flags;
    end

    assign fifo_valid = (count != '0);
    assign in_ready   = (count != CW'(DEPTH));
    assign head       = mem[rd_ptr];

`ifdef FADD_WB_BYPASS_EN
    assign bypass = !fifo_valid && in_valid && out_ready;
    always_comb begin
        out_valid  = fifo_valid || bypass;
        out_data   = '0;
        out_rd     = '0;
        out_fflags = '0;
        if (fifo_valid) begin
            out_data   = head.data;
            out_rd     = head.rd;
            out_fflags = head.fflags;
        end else if (bypass) begin
            out_data   = in_ent.data;
            out_rd     = in_ent.rd;
            out_fflags = in_ent.fflags;
        end
    end
`else
    assign bypass = 1'b0;
    // Storage is not reset. Gating on valid keeps the outputs at zero while
    // the FIFO is empty.
    always_comb begin
        out_valid  = fifo_valid;
        out_data   = '0;
        out_rd     = '0;
        out_fflags = '0;
        if (fifo_valid) begin
            out_data   = head.data;
            out_rd     = head.rd;
            out_fflags = head.fflags;
        end
    end
`endif

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    // A bypassed input is consumed at the output and never occupies a slot.
    assign push_wr  = push && !bypass && !flush;
    assign pop_fifo = pop && fifo_valid && !flush;

    always_ff @(posedge CLK) begin
        if (push_wr) mem[wr_ptr] <= in_ent;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop_fifo) rd_ptr <= rd_ptr + AW'(1);
            case ({push_wr, pop_fifo})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A pop that coincides with a clear leaves only the popped flags. A pop
    // that coincides with a flush is discarded and not accumulated.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            fflags_acc <= '0;
        end else if (fflags_clr) begin
            fflags_acc <= (pop && !flush) ? out_fflags : 5'b00000;
        end else if (pop && !flush) begin
            fflags_acc <= fflags_acc | out_fflags;
        end
    end
endmodule

// File: tb/tb_fadd_result_wb.sv
module tb_fadd_result_wb;
    logic        CLK = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_frs1, in_frs2, in_frd;
    logic        in_funct;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [4:0]  out_fflags;
    logic [4:0]  fflags_acc;
    logic        fflags_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    fadd_result_wb #(.XLEN(32), .REG_ADDR(5), .DEPTH(2)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_frs1    (in_frs1),
        .in_frs2    (in_frs2),
        .in_funct   (in_funct),
        .in_frd     (in_frd),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_fflags (out_fflags),
        .fflags_acc (fflags_acc),
        .fflags_clr (fflags_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic f,
                          input logic [31:0] r, input logic [4:0] d);
        in_frs1 = a; in_frs2 = b; in_funct = f; in_frd = r; in_rd = d;
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic f,
                         input logic [31:0] r, input logic [4:0] d);
        set_in(a, b, f, r, d);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
        set_in(32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_fflags", {27'd0, out_fflags}, 32'd0);
        chk("rst_fflags_acc", {27'd0, fflags_acc}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic add 1.0 + 2.0 = 3.0.
        push1(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'd5);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_data", out_data, 32'h40400000);
        chk("add_rd", {27'd0, out_rd}, 32'd5);
        chk("add_flags", {27'd0, out_fflags}, 32'd0);
        tick();
        chk("add_hold_data", out_data, 32'h40400000);
        pop1();
        chk("add_empty", {31'd0, out_valid}, 32'd0);
        chk("add_acc", {27'd0, fflags_acc}, 32'd0);

        // +inf + -inf is invalid.
        push1(32'h7F800000, 32'hFF800000, 1'b0, 32'h0, 5'd6);
        chk("infinf_data", out_data, 32'h7FC00000);
        chk("infinf_flags", {27'd0, out_fflags}, 32'b10000);
        pop1();
        chk("infinf_acc", {27'd0, fflags_acc}, 32'b10000);
        fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
        chk("clr_acc", {27'd0, fflags_acc}, 32'd0);

        // A signalling NaN raises NV. A quiet NaN raises nothing.
        push1(32'h7F800001, 32'h3F800000, 1'b0, 32'h12345678, 5'd7);
        chk("snan_data", out_data, 32'h7FC00000);
        chk("snan_flags", {27'd0, out_fflags}, 32'b10000);
        pop1();
        push1(32'h7FC00001, 32'h3F800000, 1'b0, 32'h12345678, 5'd8);
        chk("qnan_data", out_data, 32'h7FC00000);
        chk("qnan_flags", {27'd0, out_fflags}, 32'd0);
        pop1();
        chk("nan_acc", {27'd0, fflags_acc}, 32'b10000);
        fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;

        // 1.0 - (+inf) gives -inf because operand 2 has its sign flipped.
        push1(32'h3F800000, 32'h7F800000, 1'b1, 32'h0, 5'd9);
        chk("inf2_sub_data", out_data, 32'hFF800000);
        chk("inf2_sub_flags", {27'd0, out_fflags}, 32'd0);
        pop1();
        // -inf + -inf (not an effective subtract) gives -inf.
        push1(32'hFF800000, 32'hFF800000, 1'b0, 32'h0, 5'd9);
        chk("infsame_data", out_data, 32'hFF800000);
        chk("infsame_flags", {27'd0, out_fflags}, 32'd0);
        pop1();

        // Overflow: max finite + max finite.
        push1(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'd10);
        chk("ovf_data", out_data, 32'h7F800000);
        chk("ovf_flags", {27'd0, out_fflags}, 32'b00101);
        pop1();
        chk("ovf_acc", {27'd0, fflags_acc}, 32'b00101);

        // A clear in the same cycle as a pop keeps only the popped flags.
        push1(32'h7F800001, 32'h0, 1'b0, 32'h0, 5'd11);
        fflags_clr = 1'b1; out_ready = 1'b1; tick(); fflags_clr = 1'b0; out_ready = 1'b0;
        chk("clrpop_acc", {27'd0, fflags_acc}, 32'b10000);

        // Backpressure: rd 1, 2, 3 arrive while the output is stalled.
        set_in(32'h0, 32'h0, 1'b0, 32'd1, 5'd1); in_valid = 1'b1; tick();
        chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        set_in(32'h0, 32'h0, 1'b0, 32'd2, 5'd2); tick();
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        set_in(32'h0, 32'h0, 1'b0, 32'd3, 5'd3); tick();
        chk("bp_still_full", {31'd0, in_ready}, 32'd0);
        chk("bp_head_hold", {27'd0, out_rd}, 32'd1);
        out_ready = 1'b1; tick();
        chk("bp_pop2_rd", {27'd0, out_rd}, 32'd2);
        chk("bp_pop2_data", out_data, 32'd2);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_pop3_rd", {27'd0, out_rd}, 32'd3);
        chk("bp_pop3_valid", {31'd0, out_valid}, 32'd1);
        tick();
        out_ready = 1'b0;
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_acc", {27'd0, fflags_acc}, 32'b10000);

        // Flush with two entries queued and a push presented.
        push1(32'h7F800001, 32'h0, 1'b0, 32'h0, 5'd12);
        push1(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'd13);
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        set_in(32'h0, 32'h0, 1'b0, 32'd4, 5'd14);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("fl_empty", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_acc_kept", {27'd0, fflags_acc}, 32'b10000);
        // A flush with one entry and a possible push drops both.
        push1(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'd15);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("fl1_empty", {31'd0, out_valid}, 32'd0);
        chk("fl1_no_acc", {27'd0, fflags_acc}, 32'b10000);
        tick();
        chk("fl1_push_dropped", {31'd0, out_valid}, 32'd0);

        // Reset asserted while entries are still draining.
        fflags_clr = 1'b1; tick(); fflags_clr = 1'b0;
        push1(32'h7F800001, 32'h0, 1'b0, 32'h0, 5'd16);
        push1(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'd17);
        pop1();
        chk("rd_head", {27'd0, out_rd}, 32'd17);
        chk("rd_acc", {27'd0, fflags_acc}, 32'b10000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_acc", {27'd0, fflags_acc}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
